// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Request captured at accept and held for the whole transaction.
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  offset;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } lsu_req_t;

    function automatic logic req_rejected(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = funct3[2] | (funct3 == 3'b011);
        end else begin
            illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
        end
        misaligned = ((funct3[1:0] == 2'b01) & offset[0]) |
                     ((funct3[1:0] == 2'b10) & (offset != 2'b00));
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shift the bus word down to the addressed byte and extend.
// Latency: combinational.
// Backpressure: none.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        value   = shifted;
        case (funct3)
            F3_LB:   value = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   value = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  value = {24'h0, shifted[7:0]};
            F3_LHU:  value = {16'h0, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_axi_lite_master.sv
// Load/store unit: one RV32I load/store per instruction over AXI4-Lite, with writeback.
// Latency: zero-wait slave completes at accept+3; rejected requests at accept+1.
// Backpressure: stalls the core until done; waits on every AXI ready/valid, aborts at TIMEOUT.
module lsu_axi_lite_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,

    output logic        stall,
    output logic        done,
    output logic        err,

    output logic        rf_wr_en,
    output logic [4:0]  rf_addr_rd,
    output logic [31:0] rf_data_rd,

    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e    state;
    lsu_state_e    state_nxt;
    lsu_req_t      req_q;
    lsu_req_t      req_d;
    logic [31:0]   load_val;
    logic [31:0]   rdata_q;
    logic [CW-1:0] to_cnt;
    logic          err_q;
    logic          aw_done_q;
    logic          w_done_q;
    logic          rejected;
    logic          active;
    logic          timeout_hit;

    assign rejected    = req_rejected(req_we, req_funct3, req_addr[1:0]);
    assign active      = state inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP};
    assign timeout_hit = (TIMEOUT != 0) && active && (to_cnt == TO_LAST);

    // Store lanes: sub-word data is replicated so the strobe alone selects the bytes.
    always_comb begin
        req_d        = '0;
        req_d.we     = req_we;
        req_d.funct3 = req_funct3;
        req_d.offset = req_addr[1:0];
        req_d.rd     = req_rd;
        req_d.addr   = {req_addr[31:2], 2'b00};
        req_d.wdata  = req_wdata;
        req_d.strb   = 4'b1111;
        case (req_funct3)
            F3_SB: begin
                req_d.strb  = 4'b0001 << req_addr[1:0];
                req_d.wdata = {4{req_wdata[7:0]}};
            end
            F3_SH: begin
                req_d.strb  = 4'b0011 << req_addr[1:0];
                req_d.wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (rejected) begin
                        state_nxt = DONE;
                    end else if (req_we) begin
                        state_nxt = WR_REQ;
                    end else begin
                        state_nxt = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    state_nxt = DONE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; move on once both have been taken.
                m_axi_awvalid = ~aw_done_q;
                m_axi_wvalid  = ~w_done_q;
                if ((aw_done_q | m_axi_awready) & (w_done_q | m_axi_wready)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (timeout_hit) begin
            state_nxt = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            to_cnt    <= '0;
        end else begin
            if (active) begin
                to_cnt <= to_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q     <= req_d;
                        err_q     <= rejected;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        to_cnt    <= '0;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        err_q <= (m_axi_rresp != AXI_RESP_OKAY);
                        if (m_axi_rresp == AXI_RESP_OKAY) begin
                            rdata_q <= load_val;
                        end
                    end
                end
                WR_REQ: begin
                    aw_done_q <= aw_done_q | m_axi_awready;
                    w_done_q  <= w_done_q | m_axi_wready;
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        err_q <= (m_axi_bresp != AXI_RESP_OKAY);
                    end
                end
                default: ;
            endcase
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    lsu_load_align u_load_align (
        .rdata  (m_axi_rdata),
        .offset (req_q.offset),
        .funct3 (req_q.funct3),
        .value  (load_val)
    );

    assign done         = (state == DONE);
    assign err          = done & err_q;
    assign stall        = req_valid & ~done;
    assign rf_wr_en     = done & ~req_q.we & ~err_q & (req_q.rd != 5'd0);
    assign rf_addr_rd   = req_q.rd;
    assign rf_data_rd   = rdata_q;
    assign m_axi_araddr = req_q.addr;
    assign m_axi_awaddr = req_q.addr;
    assign m_axi_wdata  = req_q.wdata;
    assign m_axi_wstrb  = req_q.strb;

endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// Bench for lsu_axi_lite_master: scripted core requests against a configurable AXI4-Lite slave.
module tb_lsu_axi_lite_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall, done, err, rf_wr_en;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    always #5 clk = ~clk;

    lsu_axi_lite_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .stall(stall), .done(done), .err(err),
        .rf_wr_en(rf_wr_en), .rf_addr_rd(rf_addr_rd), .rf_data_rd(rf_data_rd),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct packed {
        logic        err;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [7:0]  lat;
        logic        stall_bad;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [31:0] r_dat_cfg;
    logic [1:0]  r_resp_cfg, b_resp_cfg;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    bit          ar_seen, aw_seen;

    function automatic txn_t mk(logic e, logic w, logic [4:0] rd, logic [31:0] d, int lat);
        txn_t t;
        t.err = e; t.wr = w; t.rd = rd; t.data = d; t.lat = lat[7:0]; t.stall_bad = 1'b0;
        return t;
    endfunction

    function automatic string fmt(txn_t t);
        return $sformatf("err=%b wr=%b rd=%0d data=%h lat=%0d stall_bad=%b",
                         t.err, t.wr, t.rd, t.data, t.lat, t.stall_bad);
    endfunction

    task automatic set_slave(int ar, int r, int aw, int w, int b,
                             logic [31:0] rdat, logic [1:0] rresp, logic [1:0] bresp);
        ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
        r_dat_cfg = rdat; r_resp_cfg = rresp; b_resp_cfg = bresp;
    endtask

    // Slave: decides at each falling edge; a handshake seen here completes at the next rising edge.
    initial begin : slave
        int  ar_c, r_c, aw_c, w_c, b_c;
        bit  r_pend, aw_got, w_got, ar_f, r_f, aw_f, w_f, b_f;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        r_pend = 0; aw_got = 0; w_got = 0; ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_rdata = '0; m_axi_rresp = '0; m_axi_bresp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
                m_axi_bvalid = 0;
                ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
                r_pend = 0; aw_got = 0; w_got = 0; ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
            end else begin
                if (ar_f) begin m_axi_arready = 0; r_pend = 1; r_c = 0; end
                if (r_f)  m_axi_rvalid = 0;
                if (aw_f) begin m_axi_awready = 0; aw_got = 1; end
                if (w_f)  begin m_axi_wready = 0; w_got = 1; end
                if (b_f)  m_axi_bvalid = 0;
                if (!m_axi_arvalid) begin m_axi_arready = 0; ar_c = 0; end
                else if (!m_axi_arready) begin
                    if (ar_c >= ar_dly) m_axi_arready = 1; else ar_c++;
                end
                if (!m_axi_awvalid) begin m_axi_awready = 0; aw_c = 0; end
                else if (!m_axi_awready) begin
                    if (aw_c >= aw_dly) m_axi_awready = 1; else aw_c++;
                end
                if (!m_axi_wvalid) begin m_axi_wready = 0; w_c = 0; end
                else if (!m_axi_wready) begin
                    if (w_c >= w_dly) m_axi_wready = 1; else w_c++;
                end
                if (r_pend) begin
                    if (r_c >= r_dly) begin
                        m_axi_rvalid = 1; m_axi_rdata = r_dat_cfg; m_axi_rresp = r_resp_cfg; r_pend = 0;
                    end else r_c++;
                end
                if (aw_got && w_got) begin
                    if (b_c >= b_dly) begin
                        m_axi_bvalid = 1; m_axi_bresp = b_resp_cfg; aw_got = 0; w_got = 0; b_c = 0;
                    end else b_c++;
                end
                if (m_axi_arvalid) ar_seen = 1;
                if (m_axi_awvalid || m_axi_wvalid) aw_seen = 1;
                ar_f = m_axi_arvalid && m_axi_arready;
                r_f  = m_axi_rvalid && m_axi_rready;
                aw_f = m_axi_awvalid && m_axi_awready;
                w_f  = m_axi_wvalid && m_axi_wready;
                b_f  = m_axi_bvalid && m_axi_bready;
                if (ar_f) cap_araddr = m_axi_araddr;
                if (aw_f) cap_awaddr = m_axi_awaddr;
                if (w_f) begin cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; end
            end
        end
    end

    // Core side: push the expectation, present the request, wait (bounded) for done.
    // b2b keeps presenting from the DONE cycle itself, so the request must not be taken there.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input bit b2b,
                         input txn_t exp, output txn_t obs);
        int cyc;
        bit got;
        exp_q.push_back(exp);
        if (!b2b) @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1;
        obs = '0; got = 0; cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                got = 1;
                obs.err  = err;
                obs.wr   = rf_wr_en;
                obs.rd   = rf_wr_en ? rf_addr_rd : 5'd0;
                obs.data = rf_wr_en ? rf_data_rd : 32'd0;
                obs.lat  = cyc[7:0];
                if (stall !== 1'b0) obs.stall_bad = 1'b1;
            end else if (stall !== 1'b1) begin
                obs.stall_bad = 1'b1;
            end
        end
        if (!got) obs.lat = 8'hFF;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        set_slave(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({stall, done, err, rf_wr_en, m_axi_arvalid, m_axi_rready, m_axi_awvalid,
             m_axi_wvalid, m_axi_bready} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b%b%b%b_%b%b%b%b%b want 0000_00000", stall, done, err,
                     rf_wr_en, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready);
        end
        checks++;
        if (rf_data_rd !== 32'h0) begin
            errors++; $display("FAIL reset_rf_data got %h want 00000000", rf_data_rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_word();
        txn_t o, e;
        set_slave(2, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 2'b00);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b0, mk(0, 1, 5, 32'hDEADBEEF, 5), o);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL lw_basic got %s want %s", fmt(o), fmt(e)); end
        checks++;
        if (cap_araddr !== 32'h100) begin
            errors++; $display("FAIL lw_araddr got %h want 00000100", cap_araddr);
        end
        @(negedge clk);
        checks++;
        if ({rf_wr_en, done} !== 2'b00) begin
            errors++; $display("FAIL lw_pulse_width got wr_en,done=%b%b want 00", rf_wr_en, done);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] adr [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h200};
        logic [4:0]  rds [5] = '{5'd6, 5'd7, 5'd8, 5'd9, 5'd0};
        logic [31:0] val [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0};
        txn_t o, e;
        set_slave(0, 0, 0, 0, 0, 32'h80FF_0000, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, f3s[i], adr[i], 32'h0, rds[i], 1'b0,
                  mk(0, rds[i] != 5'd0, rds[i], val[i], 3), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL load_ext[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_store_half();
        txn_t o, e;
        set_slave(0, 0, 0, 3, 0, 32'h0, 2'b00, 2'b00);
        issue(1'b1, 3'b001, 32'h102, 32'h0000_1234, 5'd3, 1'b0, mk(0, 0, 0, 32'h0, 6), o);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL sh_txn got %s want %s", fmt(o), fmt(e)); end
        checks++;
        if ({cap_awaddr, cap_wstrb, cap_wdata} !== {32'h100, 4'b1100, 32'h12341234}) begin
            errors++;
            $display("FAIL sh_bus got awaddr=%h wstrb=%b wdata=%h want 00000100 1100 12341234",
                     cap_awaddr, cap_wstrb, cap_wdata);
        end
    endtask

    task automatic test_reject();
        logic        wes [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010, 3'b111};
        logic [31:0] adr [6] = '{32'h101, 32'h201, 32'h100, 32'h100, 32'h102, 32'h0};
        txn_t o, e;
        set_slave(0, 0, 0, 0, 0, 32'h5555_5555, 2'b00, 2'b00);
        ar_seen = 0; aw_seen = 0;
        for (int i = 0; i < 6; i++) begin
            issue(wes[i], f3s[i], adr[i], 32'hFFFF_FFFF, 5'd12, 1'b0, mk(1, 0, 0, 32'h0, 1), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL reject[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
        end
        checks++;
        if ({ar_seen, aw_seen} !== 2'b00) begin
            errors++; $display("FAIL reject_no_bus got ar,aw seen=%b%b want 00", ar_seen, aw_seen);
        end
    endtask

    task automatic test_bus_error();
        txn_t o, e;
        set_slave(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b10);
        issue(1'b1, 3'b010, 32'h10, 32'hA5A5_A5A5, 5'd0, 1'b0, mk(1, 0, 0, 32'h0, 3), o);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL sw_slverr got %s want %s", fmt(o), fmt(e)); end
        set_slave(0, 0, 0, 0, 0, 32'h7777_7777, 2'b11, 2'b00);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 5'd9, 1'b0, mk(1, 0, 0, 32'h0, 3), o);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL lw_decerr got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_back_to_back();
        txn_t o, e;
        set_slave(0, 0, 0, 0, 0, 32'h1122_3344, 2'b00, 2'b00);
        issue(1'b1, 3'b000, 32'h101, 32'h0000_00AB, 5'd0, 1'b0, mk(0, 0, 0, 32'h0, 3), o);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_sb got %s want %s", fmt(o), fmt(e)); end
        issue(1'b0, 3'b010, 32'h104, 32'h0, 5'd3, 1'b1, mk(0, 1, 3, 32'h11223344, 4), o);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_lw got %s want %s", fmt(o), fmt(e)); end
        checks++;
        if ({cap_wstrb, cap_wdata, cap_araddr} !== {4'b0010, 32'hABABABAB, 32'h104}) begin
            errors++;
            $display("FAIL b2b_bus got wstrb=%b wdata=%h araddr=%h want 0010 abababab 00000104",
                     cap_wstrb, cap_wdata, cap_araddr);
        end
    endtask

    task automatic test_timeout();
        txn_t o, e;
        set_slave(1000, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
        issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd4, 1'b0, mk(1, 0, 0, 32'h0, TO + 1), o);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL timeout got %s want %s", fmt(o), fmt(e)); end
        checks++;
        if (m_axi_arvalid !== 1'b0) begin
            errors++; $display("FAIL timeout_arvalid got %b want 0", m_axi_arvalid);
        end
    endtask

    task automatic test_reset_mid();
        txn_t o, e;
        set_slave(0, 6, 0, 0, 0, 32'h0BAD_0BAD, 2'b00, 2'b00);
        @(negedge clk);
        req_we = 0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 0; req_rd = 5'd11;
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (m_axi_rready !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_rd_data got rready=%b want 1", m_axi_rready);
        end
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, done, err, rf_wr_en, m_axi_arvalid, m_axi_rready, m_axi_awvalid,
             m_axi_wvalid, m_axi_bready} !== 9'b0 || rf_data_rd !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got ctrl=%b%b%b%b_%b%b%b%b%b rf_data=%h want all zero",
                     stall, done, err, rf_wr_en, m_axi_arvalid, m_axi_rready, m_axi_awvalid,
                     m_axi_wvalid, m_axi_bready, rf_data_rd);
        end
        @(negedge clk);
        rst = 1'b0;
        set_slave(0, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 2'b00);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd10, 1'b0, mk(0, 1, 10, 32'hCAFEF00D, 3), o);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL rstmid_after got %s want %s", fmt(o), fmt(e)); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store_half();
        test_reject();
        test_bus_error();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

endmodule
